// File: rtl/max_pool_stream_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// max_pool_stream_if : byte-in / max-out valid-ready stream pair
// Revision: 1.0
// ---------------------------------------------------------------------------
interface max_pool_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic       out_last;
  logic       out_partial;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_last, out_partial
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_last, out_partial
  );
endinterface
`default_nettype wire

// File: rtl/max_pool_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// max_pool_stream : groups bytes into 8-sample windows, emits each window max
// Revision: 1.0
// ---------------------------------------------------------------------------
module sort_8 (
  input  logic [7:0][7:0] d,
  output logic [7:0]      max_o
);
  logic [3:0][7:0] lvl1;
  logic [1:0][7:0] lvl2;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
      assign lvl1[i] = (d[2*i] > d[2*i+1]) ? d[2*i] : d[2*i+1];
    end
    for (genvar j = 0; j < 2; j++) begin : g_lvl2
      assign lvl2[j] = (lvl1[2*j] > lvl1[2*j+1]) ? lvl1[2*j] : lvl1[2*j+1];
    end
  endgenerate

  assign max_o = (lvl2[0] > lvl2[1]) ? lvl2[0] : lvl2[1];
endmodule

module max_pool_stream #(
  parameter int FRAME_WINS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  max_pool_stream_if.slave   bus
);
  localparam logic [7:0] c_last_win = 8'(FRAME_WINS - 1);

  logic [7:0][7:0] win_q, win_d;
  logic [2:0]      fill_q, fill_d;
  logic [7:0]      win_cnt_q, win_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_max_q, out_max_d;
  logic            out_last_q, out_last_d;
  logic            out_partial_q, out_partial_d;

  logic            in_ready;
  logic            acc;
  logic            closing;
  logic [7:0][7:0] slot;
  logic [7:0]      win_max;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign acc      = bus.in_valid & in_ready;
  assign closing  = acc & ((fill_q == 3'd7) | bus.in_last);

  // Slots beyond the incoming sample are zero, which never wins an unsigned max.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_slot
      assign slot[i] = (3'(i) < fill_q)  ? win_q[i]    :
                       (3'(i) == fill_q) ? bus.in_data : 8'd0;
    end
  endgenerate

  sort_8 u_sort_8 (
    .d     (slot),
    .max_o (win_max)
  );

  always_comb begin
    win_d         = win_q;
    fill_d        = fill_q;
    win_cnt_d     = win_cnt_q;
    out_valid_d   = out_valid_q;
    out_max_d     = out_max_q;
    out_last_d    = out_last_q;
    out_partial_d = out_partial_q;

    if (acc) begin
      win_d[fill_q] = bus.in_data;
      fill_d        = closing ? 3'd0 : fill_q + 3'd1;
    end

    if (closing) begin
      out_valid_d   = 1'b1;
      out_max_d     = win_max;
      out_last_d    = bus.in_last | (win_cnt_q == c_last_win);
      out_partial_d = bus.in_last & (fill_q != 3'd7);
      win_cnt_d     = (bus.in_last | (win_cnt_q == c_last_win)) ? 8'd0 : win_cnt_q + 8'd1;
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      win_d         = '0;
      fill_d        = 3'd0;
      win_cnt_d     = 8'd0;
      out_valid_d   = 1'b0;
      out_max_d     = 8'd0;
      out_last_d    = 1'b0;
      out_partial_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q         <= '0;
      fill_q        <= 3'd0;
      win_cnt_q     <= 8'd0;
      out_valid_q   <= 1'b0;
      out_max_q     <= 8'd0;
      out_last_q    <= 1'b0;
      out_partial_q <= 1'b0;
    end else begin
      win_q         <= win_d;
      fill_q        <= fill_d;
      win_cnt_q     <= win_cnt_d;
      out_valid_q   <= out_valid_d;
      out_max_q     <= out_max_d;
      out_last_q    <= out_last_d;
      out_partial_q <= out_partial_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_max     = out_max_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_partial = out_partial_q;
endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_max_pool_stream : directed and random checks of max_pool_stream
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_max_pool_stream;
  localparam int FW_A = 16;
  localparam int FW_B = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  always #5 clk = ~clk;

  max_pool_stream_if bus_a ();
  max_pool_stream_if bus_b ();

  max_pool_stream #(.FRAME_WINS(FW_A)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_a.slave));
  max_pool_stream #(.FRAME_WINS(FW_B)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_b.slave));

  typedef struct {
    logic [7:0] mx;
    logic       last_a;
    logic       last_b;
    logic       part;
  } res_t;

  res_t       exp_q[$];
  int         cur_n;
  logic [7:0] cur_max;
  int         wcnt_a, wcnt_b;
  int         errors = 0;
  int         checks = 0;

  logic       o_acc, o_drain, o_rdy, o_rdy_b, o_vld;
  logic [7:0] o_max;
  logic       o_last_a, o_last_b, o_part;

  function automatic void model_clear();
    exp_q.delete();
    cur_n = 0; cur_max = 8'd0; wcnt_a = 0; wcnt_b = 0;
  endfunction

  // Window = up to 8 accepted samples, closed early by in_last.
  function automatic void model_accept(logic [7:0] d, logic l);
    res_t r;
    if (d > cur_max) cur_max = d;
    cur_n++;
    if (cur_n == 8 || l) begin
      r.mx     = cur_max;
      r.last_a = l || (wcnt_a == FW_A - 1);
      r.last_b = l || (wcnt_b == FW_B - 1);
      r.part   = l && (cur_n < 8);
      exp_q.push_back(r);
      wcnt_a  = r.last_a ? 0 : wcnt_a + 1;
      wcnt_b  = r.last_b ? 0 : wcnt_b + 1;
      cur_n   = 0;
      cur_max = 8'd0;
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l; bus_a.out_ready = r;
    bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l; bus_b.out_ready = r;
  endtask

  // One clock: drive at negedge, observe just before the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    drive(v, d, l, r);
    #1;
    o_rdy    = bus_a.in_ready;
    o_rdy_b  = bus_b.in_ready;
    o_vld    = bus_a.out_valid;
    o_max    = bus_a.out_max;
    o_last_a = bus_a.out_last;
    o_last_b = bus_b.out_last;
    o_part   = bus_a.out_partial;
    o_acc    = v & o_rdy;
    o_drain  = o_vld & r;
    if (o_acc) model_accept(d, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    checks++;
    if ({o_vld, o_max, o_last_a, o_part, o_rdy} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got vld=%0b max=%0d last=%0b part=%0b rdy=%0b, want 0 0 0 0 1",
               o_vld, o_max, o_last_a, o_part, o_rdy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq [8] = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd7, 8'd0, 8'd5};
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0, 1'b1);
      if (o_vld !== 1'b0 || o_acc !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL basic_fill: got %0d odd cycles while filling, want 0", early);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max, o_part, o_last_a, o_last_b} !== {1'b1, 8'd200, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got vld=%0b max=%0d part=%0b last=%0b/%0b, want 1 200 0 0/0",
               o_vld, o_max, o_part, o_last_a, o_last_b);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if (o_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got out_valid=%0b, want 0", o_vld);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < 8) ? 8'hFF : 8'h00, 1'b0, 1'b1);
      if (o_rdy !== 1'b1) stalls++;
      if (i == 8) begin
        checks++;
        if ({o_vld, o_max} !== {1'b1, 8'hFF}) begin
          errors++;
          $display("FAIL b2b_first: got vld=%0b max=%0h, want 1 ff", o_vld, o_max);
        end
      end
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL b2b_bubble: got %0d stalled cycles, want 0", stalls);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL b2b_second: got vld=%0b max=%0h, want 1 00", o_vld, o_max);
    end
  endtask

  task automatic test_partial();
    step(1'b1, 8'd4, 1'b0, 1'b1);
    step(1'b1, 8'd2, 1'b0, 1'b1);
    step(1'b1, 8'd6, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max, o_part, o_last_a, o_last_b} !== {1'b1, 8'd6, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL partial: got vld=%0b max=%0d part=%0b last=%0b/%0b, want 1 6 1 1/1",
               o_vld, o_max, o_part, o_last_a, o_last_b);
    end
    // Rising values: a stale fill would close early with a smaller max.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 8'(10 + 8*k + i), 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      checks++;
      if ({o_vld, o_max, o_part, o_last_a, o_last_b} !==
          {1'b1, 8'(17 + 8*k), 1'b0, 1'b0, (k == 1)}) begin
        errors++;
        $display("FAIL after_partial_%0d: got vld=%0b max=%0d part=%0b last=%0b/%0b, want 1 %0d 0 0/%0b",
                 k, o_vld, o_max, o_part, o_last_a, o_last_b, 17 + 8*k, (k == 1));
      end
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 8'(1 + i), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 8'd99, 1'b0, 1'b0);
      if (o_vld !== 1'b1 || o_max !== 8'd8 || o_rdy !== 1'b0 || o_acc !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: got %0d cycles not holding max=8 with in_ready=0, want 0", bad);
    end
    step(1'b1, 8'd99, 1'b0, 1'b1);
    checks++;
    if ({o_drain, o_max, o_acc} !== {1'b1, 8'd8, 1'b1}) begin
      errors++;
      $display("FAIL release: got drain=%0b max=%0d acc=%0b, want 1 8 1", o_drain, o_max, o_acc);
    end
    for (int i = 0; i < 7; i++) step(1'b1, 8'(20 + i), 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max} !== {1'b1, 8'd99}) begin
      errors++;
      $display("FAIL no_loss: got vld=%0b max=%0d, want 1 99", o_vld, o_max);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic do_clr();
    // Offer a sample during clr: it must not be taken.
    drive(1'b1, 8'd250, 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    model_clear();
  endtask

  // Random traffic with backpressure, scoreboarded against the model.
  task automatic run_random(input int n_samples, input int last_pct,
                            output int n_win, output int n_last_a, output int n_last_b);
    int   sent = 0;
    int   cyc  = 0;
    logic v, l, r;
    res_t e;
    n_win = 0; n_last_a = 0; n_last_b = 0;
    while ((sent < n_samples || exp_q.size() != 0 || o_vld) && cyc < 3000) begin
      v = (sent < n_samples) && ($urandom_range(99) < 75);
      l = v && ($urandom_range(99) < last_pct);
      r = ($urandom_range(99) < 70);
      step(v, 8'($urandom), l, r);
      cyc++;
      if (o_acc) sent++;
      checks++;
      if (o_rdy !== (~o_vld | r) || o_rdy_b !== o_rdy) begin
        errors++;
        $display("FAIL rand_ready: got rdy=%0b/%0b, want %0b", o_rdy, o_rdy_b, ~o_vld | r);
      end
      if (o_drain) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got unexpected result max=%0d, want none", o_max);
        end else begin
          e = exp_q.pop_front();
          n_win++;
          if (o_last_a) n_last_a++;
          if (o_last_b) n_last_b++;
          if ({o_max, o_last_a, o_last_b, o_part} !== {e.mx, e.last_a, e.last_b, e.part}) begin
            errors++;
            $display("FAIL rand_result: got max=%0d last=%0b/%0b part=%0b, want max=%0d last=%0b/%0b part=%0b",
                     o_max, o_last_a, o_last_b, o_part, e.mx, e.last_a, e.last_b, e.part);
          end
        end
      end
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL rand_timeout: got %0d of %0d samples sent, want all and queue empty", sent, n_samples);
    end
  endtask

  task automatic test_frame_wins();
    int nw, la, lb;
    do_clr();
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL clr: got vld=%0b max=%0d, want 0 0", o_vld, o_max);
    end
    run_random(32, 0, nw, la, lb);
    checks++;
    if (nw != 4 || la != 0 || lb != 2) begin
      errors++;
      $display("FAIL frame_wins: got windows=%0d last16=%0d last2=%0d, want 4 0 2", nw, la, lb);
    end
  endtask

  task automatic test_random_last();
    int nw, la, lb;
    run_random(300, 10, nw, la, lb);
    checks++;
    if (nw < 30) begin
      errors++;
      $display("FAIL random_last: got %0d windows, want at least 30", nw);
    end
  endtask

  task automatic test_reset_midwindow();
    for (int i = 0; i < 5; i++) step(1'b1, 8'd250, 1'b0, 1'b1);
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(1 + i), 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({o_vld, o_max, o_part, o_last_a} !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got vld=%0b max=%0d part=%0b last=%0b, want 1 8 0 0",
               o_vld, o_max, o_part, o_last_a);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_frame_wins();
    test_random_last();
    test_reset_midwindow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
